// File: rtl/nn_job_scheduler.sv
// nn_job_scheduler: runs one inference job at a time, RX frame buffer -> loader -> NN -> TX reply.
// Optional NN watchdog (abort + timeout counter) is built only when NN_JOB_WATCHDOG_EN is defined.

module nn_job_scheduler #(
  parameter int RESULT_W       = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                FRAME_READY,
  input  logic [0:31]         SRC_IP_ADDRESS_IP,
  input  logic [0:47]         SRC_MAC_ADDRESS_IP,
  input  logic [0:15]         SRC_UDP_PORT_IP,
  output logic                RX_BUSY,
  output logic                LOAD_START,
  input  logic                LOAD_DONE,
  output logic                NN_START,
  input  logic                NN_DONE,
  input  logic [RESULT_W-1:0] NN_RESULT,
  output logic                NN_ABORT,
  output logic                TX_VALID,
  input  logic                TX_READY,
  output logic [RESULT_W-1:0] TX_RESULT,
  output logic [0:31]         SRC_IP_ADDRESS_NN,
  output logic [0:47]         SRC_MAC_ADDRESS_NN,
  output logic [0:15]         SRC_UDP_PORT_NN,
  output logic [15:0]         DROP_COUNT,
  output logic [7:0]          TIMEOUT_COUNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_INFER = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t r_state;
  state_t r_prev_state;
  state_t w_next_state;

  logic                r_pend_valid;
  logic [0:31]         r_pend_ip;
  logic [0:47]         r_pend_mac;
  logic [0:15]         r_pend_port;
  logic [0:31]         r_ip_nn;
  logic [0:47]         r_mac_nn;
  logic [0:15]         r_port_nn;
  logic [RESULT_W-1:0] r_tx_result;
  logic [15:0]         r_drop_count;

  logic w_frame_accept;
  logic w_frame_drop;
  logic w_start_job;
  logic w_wd_expire;

  assign w_start_job    = (r_state == S_IDLE) && r_pend_valid;
  assign w_frame_accept = FRAME_READY && !RX_BUSY;
  assign w_frame_drop   = FRAME_READY && RX_BUSY;

`ifdef NN_JOB_WATCHDOG_EN
  logic [31:0] r_wd_cnt;
  logic [7:0]  r_timeout_count;

  // NN_DONE on the expiry cycle wins, so it masks the abort.
  assign w_wd_expire = (r_state == S_INFER) && !NN_DONE && (r_wd_cnt == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wd_cnt        <= '0;
      r_timeout_count <= '0;
    end else begin
      if ((r_state == S_LOAD) && LOAD_DONE) begin
        r_wd_cnt <= '0;
      end else if (r_state == S_INFER) begin
        r_wd_cnt <= r_wd_cnt + 32'd1;
      end
      if (w_wd_expire && (r_timeout_count != 8'hFF)) begin
        r_timeout_count <= r_timeout_count + 8'd1;
      end
    end
  end

  assign NN_ABORT      = w_wd_expire;
  assign TIMEOUT_COUNT = r_timeout_count;
`else
  assign w_wd_expire   = 1'b0;
  assign NN_ABORT      = 1'b0;
  assign TIMEOUT_COUNT = '0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values;
  // blocking assignments here would make results depend on statement order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= S_IDLE;
      r_prev_state <= S_IDLE;
    end else begin
      r_state      <= w_next_state;
      r_prev_state <= r_state;
    end
  end

  always_comb begin
    // NOTE: default assignment first so every path drives w_next_state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (r_pend_valid) w_next_state = S_LOAD;
      S_LOAD:  if (LOAD_DONE)    w_next_state = S_INFER;
      S_INFER: begin
        if (NN_DONE)          w_next_state = S_SEND;
        else if (w_wd_expire) w_next_state = S_IDLE;
      end
      S_SEND:  if (TX_READY)     w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Start pulses fire only on the first cycle of their state, detected via the previous state.
  always_comb begin
    RX_BUSY    = r_pend_valid || (r_state == S_LOAD);
    LOAD_START = (r_state == S_LOAD)  && (r_prev_state != S_LOAD);
    NN_START   = (r_state == S_INFER) && (r_prev_state != S_INFER);
    TX_VALID   = (r_state == S_SEND);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_pend_valid <= 1'b0;
      r_pend_ip    <= '0;
      r_pend_mac   <= '0;
      r_pend_port  <= '0;
      r_ip_nn      <= '0;
      r_mac_nn     <= '0;
      r_port_nn    <= '0;
      r_tx_result  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_frame_accept) begin
        r_pend_valid <= 1'b1;
        r_pend_ip    <= SRC_IP_ADDRESS_IP;
        r_pend_mac   <= SRC_MAC_ADDRESS_IP;
        r_pend_port  <= SRC_UDP_PORT_IP;
      end else if (w_start_job) begin
        r_pend_valid <= 1'b0;
      end

      if (w_start_job) begin
        r_ip_nn   <= r_pend_ip;
        r_mac_nn  <= r_pend_mac;
        r_port_nn <= r_pend_port;
      end

      if ((r_state == S_INFER) && NN_DONE) begin
        r_tx_result <= NN_RESULT;
      end

      if (w_frame_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign TX_RESULT          = r_tx_result;
  assign SRC_IP_ADDRESS_NN  = r_ip_nn;
  assign SRC_MAC_ADDRESS_NN = r_mac_nn;
  assign SRC_UDP_PORT_NN    = r_port_nn;
  assign DROP_COUNT         = r_drop_count;

endmodule

// File: tb/tb_nn_job_scheduler.sv
// Self-checking bench for nn_job_scheduler: scenario tasks plus a reply scoreboard.
// Define NN_JOB_WATCHDOG_EN to also exercise the watchdog with TIMEOUT_CYCLES=100.

module tb_nn_job_scheduler;

  localparam int RW = 8;
`ifdef NN_JOB_WATCHDOG_EN
  localparam int TB_TIMEOUT = 100;
`else
  localparam int TB_TIMEOUT = 65535;
`endif

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          FRAME_READY;
  logic [0:31]   SRC_IP_ADDRESS_IP;
  logic [0:47]   SRC_MAC_ADDRESS_IP;
  logic [0:15]   SRC_UDP_PORT_IP;
  logic          RX_BUSY;
  logic          LOAD_START;
  logic          LOAD_DONE;
  logic          NN_START;
  logic          NN_DONE;
  logic [RW-1:0] NN_RESULT;
  logic          NN_ABORT;
  logic          TX_VALID;
  logic          TX_READY;
  logic [RW-1:0] TX_RESULT;
  logic [0:31]   SRC_IP_ADDRESS_NN;
  logic [0:47]   SRC_MAC_ADDRESS_NN;
  logic [0:15]   SRC_UDP_PORT_NN;
  logic [15:0]   DROP_COUNT;
  logic [7:0]    TIMEOUT_COUNT;

  nn_job_scheduler #(.RESULT_W(RW), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .FRAME_READY(FRAME_READY),
    .SRC_IP_ADDRESS_IP(SRC_IP_ADDRESS_IP), .SRC_MAC_ADDRESS_IP(SRC_MAC_ADDRESS_IP),
    .SRC_UDP_PORT_IP(SRC_UDP_PORT_IP), .RX_BUSY(RX_BUSY), .LOAD_START(LOAD_START),
    .LOAD_DONE(LOAD_DONE), .NN_START(NN_START), .NN_DONE(NN_DONE), .NN_RESULT(NN_RESULT),
    .NN_ABORT(NN_ABORT), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_RESULT(TX_RESULT),
    .SRC_IP_ADDRESS_NN(SRC_IP_ADDRESS_NN), .SRC_MAC_ADDRESS_NN(SRC_MAC_ADDRESS_NN),
    .SRC_UDP_PORT_NN(SRC_UDP_PORT_NN), .DROP_COUNT(DROP_COUNT), .TIMEOUT_COUNT(TIMEOUT_COUNT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0]   ip;
    logic [47:0]   mac;
    logic [15:0]   port;
    logic [RW-1:0] res;
  } reply_t;

  reply_t        sb_q[$];
  int            n_checks  = 0;
  int            n_fail    = 0;
  int            exp_drops = 0;
  logic [RW-1:0] last_res  = '0;

  function automatic reply_t mk(input logic [31:0] ip, input logic [47:0] mac,
                                input logic [15:0] port, input logic [RW-1:0] res);
    reply_t r;
    r.ip = ip; r.mac = mac; r.port = port; r.res = res;
    return r;
  endfunction

  // Advance n clock edges, landing 1 time unit after the last rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic drive_frame(input reply_t f);
    FRAME_READY        = 1'b1;
    SRC_IP_ADDRESS_IP  = f.ip;
    SRC_MAC_ADDRESS_IP = f.mac;
    SRC_UDP_PORT_IP    = f.port;
    tick();
    FRAME_READY        = 1'b0;
    SRC_IP_ADDRESS_IP  = ~f.ip;
    SRC_MAC_ADDRESS_IP = ~f.mac;
    SRC_UDP_PORT_IP    = ~f.port;
  endtask

  task automatic pulse_load_done();
    LOAD_DONE = 1'b1;
    tick();
    LOAD_DONE = 1'b0;
  endtask

  task automatic pulse_nn_done(input logic [RW-1:0] res);
    NN_DONE   = 1'b1;
    NN_RESULT = res;
    tick();
    NN_DONE   = 1'b0;
    NN_RESULT = ~res;
  endtask

  // Waits (bounded) for TX_VALID, accepts the reply and scores it against the oldest expectation.
  task automatic tx_accept(input string tag);
    reply_t e;
    bit     seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (TX_VALID === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_tx_wait: TX_VALID=%b after 32 cycles, required 1", tag, TX_VALID);
      return;
    end
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected_reply: reply seen with empty scoreboard, required none", tag);
      return;
    end
    e = sb_q.pop_front();
    n_checks++;
    if (TX_RESULT !== e.res) begin
      n_fail++;
      $display("FAIL %s_tx_result: got %h, required %h", tag, TX_RESULT, e.res);
    end
    n_checks++;
    if ({SRC_IP_ADDRESS_NN, SRC_MAC_ADDRESS_NN, SRC_UDP_PORT_NN} !== {e.ip, e.mac, e.port}) begin
      n_fail++;
      $display("FAIL %s_tx_meta: got %h/%h/%h, required %h/%h/%h", tag, SRC_IP_ADDRESS_NN,
               SRC_MAC_ADDRESS_NN, SRC_UDP_PORT_NN, e.ip, e.mac, e.port);
    end
    last_res = e.res;
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    n_checks++;
    if (TX_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_tx_release: TX_VALID=%b after handshake, required 0", tag, TX_VALID);
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    FRAME_READY = 1'b0; LOAD_DONE = 1'b0; NN_DONE = 1'b0; TX_READY = 1'b0; NN_RESULT = '0;
    SRC_IP_ADDRESS_IP = '0; SRC_MAC_ADDRESS_IP = '0; SRC_UDP_PORT_IP = '0;
    tick(2);
    n_checks++;
    if ({RX_BUSY, LOAD_START, NN_START, NN_ABORT, TX_VALID} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/ls/ns/abort/txv=%b, required 00000",
               {RX_BUSY, LOAD_START, NN_START, NN_ABORT, TX_VALID});
    end
    n_checks++;
    if ({TX_RESULT, SRC_IP_ADDRESS_NN, SRC_MAC_ADDRESS_NN, SRC_UDP_PORT_NN, DROP_COUNT,
         TIMEOUT_COUNT} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: res=%h ip=%h drop=%h tmo=%h, required all 0",
               TX_RESULT, SRC_IP_ADDRESS_NN, DROP_COUNT, TIMEOUT_COUNT);
    end
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_single_job();
    reply_t a = mk(32'h0A00_0001, 48'h0200_0000_0001, 16'd1234, 8'd7);
    bit     bad = 1'b0;
    sb_q.push_back(a);
    drive_frame(a);
    n_checks++;
    if ({RX_BUSY, LOAD_START} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_t1: busy/ls=%b, required 10", {RX_BUSY, LOAD_START});
    end
    tick();
    n_checks++;
    if ({RX_BUSY, LOAD_START} !== 2'b11) begin
      n_fail++;
      $display("FAIL single_load_start_t2: busy/ls=%b, required 11", {RX_BUSY, LOAD_START});
    end
    n_checks++;
    if ({SRC_IP_ADDRESS_NN, SRC_UDP_PORT_NN} !== {a.ip, a.port}) begin
      n_fail++;
      $display("FAIL single_meta_load: ip/port=%h/%h, required %h/%h",
               SRC_IP_ADDRESS_NN, SRC_UDP_PORT_NN, a.ip, a.port);
    end
    tick();
    n_checks++;
    if ({RX_BUSY, LOAD_START} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_load_hold: busy/ls=%b, required 10", {RX_BUSY, LOAD_START});
    end
    tick(2);
    pulse_load_done();
    n_checks++;
    if ({RX_BUSY, NN_START} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_nn_start: busy/ns=%b, required 01", {RX_BUSY, NN_START});
    end
    tick();
    n_checks++;
    if (NN_START !== 1'b0) begin
      n_fail++;
      $display("FAIL single_nn_start_pulse: NN_START=%b on 2nd INFER cycle, required 0", NN_START);
    end
    pulse_nn_done(a.res);
    n_checks++;
    if ({TX_VALID, TX_RESULT} !== {1'b1, a.res}) begin
      n_fail++;
      $display("FAIL single_tx_latency: txv/res=%b/%h, required 1/%h", TX_VALID, TX_RESULT, a.res);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({TX_VALID, TX_RESULT, SRC_IP_ADDRESS_NN, SRC_MAC_ADDRESS_NN, SRC_UDP_PORT_NN} !==
          {1'b1, a.res, a.ip, a.mac, a.port}) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL single_tx_hold: txv/res=%b/%h during stall, required 1/%h stable",
               TX_VALID, TX_RESULT, a.res);
    end
    tx_accept("single");
  endtask

  task automatic test_overlap();
    reply_t b = mk(32'hC0A8_0002, 48'h0200_0000_00B2, 16'd5001, 8'h3C);
    reply_t c = mk(32'hC0A8_0003, 48'h0200_0000_00C3, 16'd5002, 8'h81);
    reply_t d = mk(32'hDEAD_0004, 48'h0200_0000_00D4, 16'd5003, 8'h00);
    sb_q.push_back(b);
    drive_frame(b);
    tick();
    pulse_load_done();
    sb_q.push_back(c);
    drive_frame(c);
    n_checks++;
    if ({RX_BUSY, DROP_COUNT} !== {1'b1, 16'(exp_drops)}) begin
      n_fail++;
      $display("FAIL overlap_accept: busy/drops=%b/%0d, required 1/%0d", RX_BUSY, DROP_COUNT, exp_drops);
    end
    tick();
    drive_frame(d);
    exp_drops++;
    n_checks++;
    if (DROP_COUNT !== 16'(exp_drops)) begin
      n_fail++;
      $display("FAIL overlap_drop: DROP_COUNT=%0d, required %0d", DROP_COUNT, exp_drops);
    end
    pulse_nn_done(b.res);
    tick(2);
    tx_accept("overlap_b");
    n_checks++;
    if ({LOAD_START, TX_VALID, RX_BUSY} !== 3'b001) begin
      n_fail++;
      $display("FAIL overlap_idle_gap: ls/txv/busy=%b, required 001", {LOAD_START, TX_VALID, RX_BUSY});
    end
    tick();
    n_checks++;
    if ({LOAD_START, SRC_IP_ADDRESS_NN, SRC_UDP_PORT_NN} !== {1'b1, c.ip, c.port}) begin
      n_fail++;
      $display("FAIL overlap_second_start: ls=%b ip=%h, required 1 %h", LOAD_START, SRC_IP_ADDRESS_NN, c.ip);
    end
    pulse_load_done();
    pulse_nn_done(c.res);
    tx_accept("overlap_c");
  endtask

  task automatic test_drops();
    reply_t e = mk(32'h0A00_0005, 48'h0200_0000_00E5, 16'd5005, 8'h55);
    reply_t x = mk(32'hBAD0_0001, 48'h0BAD_0000_0001, 16'hBAD1, 8'h00);
    reply_t y = mk(32'hBAD0_0002, 48'h0BAD_0000_0002, 16'hBAD2, 8'h00);
    sb_q.push_back(e);
    drive_frame(e);
    drive_frame(x);
    exp_drops++;
    n_checks++;
    if ({LOAD_START, SRC_IP_ADDRESS_NN} !== {1'b1, e.ip}) begin
      n_fail++;
      $display("FAIL drops_job_start: ls=%b ip=%h, required 1 %h", LOAD_START, SRC_IP_ADDRESS_NN, e.ip);
    end
    drive_frame(y);
    exp_drops++;
    n_checks++;
    if (DROP_COUNT !== 16'(exp_drops)) begin
      n_fail++;
      $display("FAIL drops_count: DROP_COUNT=%0d, required %0d", DROP_COUNT, exp_drops);
    end
    pulse_load_done();
    pulse_nn_done(e.res);
    tx_accept("drops");
    tick();
    n_checks++;
    if ({RX_BUSY, LOAD_START} !== 2'b00) begin
      n_fail++;
      $display("FAIL drops_no_phantom: busy/ls=%b, required 00", {RX_BUSY, LOAD_START});
    end
  endtask

  task automatic test_stray_handshakes();
    reply_t g = mk(32'h0A00_0007, 48'h0200_0000_0007, 16'd7007, 8'h12);
    LOAD_DONE = 1'b1; NN_DONE = 1'b1; NN_RESULT = 8'hFF; TX_READY = 1'b1;
    tick();
    LOAD_DONE = 1'b0; NN_DONE = 1'b0; TX_READY = 1'b0;
    n_checks++;
    if ({RX_BUSY, LOAD_START, NN_START, TX_VALID, TX_RESULT} !== {4'b0000, last_res}) begin
      n_fail++;
      $display("FAIL stray_idle: busy/ls/ns/txv=%b res=%h, required 0000 %h",
               {RX_BUSY, LOAD_START, NN_START, TX_VALID}, TX_RESULT, last_res);
    end
    sb_q.push_back(g);
    drive_frame(g);
    tick();
    NN_DONE = 1'b1; NN_RESULT = 8'hFF; TX_READY = 1'b1;
    tick();
    NN_DONE = 1'b0; TX_READY = 1'b0;
    n_checks++;
    if ({RX_BUSY, NN_START, TX_VALID, TX_RESULT} !== {3'b100, last_res}) begin
      n_fail++;
      $display("FAIL stray_load: busy/ns/txv=%b res=%h, required 100 %h",
               {RX_BUSY, NN_START, TX_VALID}, TX_RESULT, last_res);
    end
    pulse_load_done();
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    n_checks++;
    if ({NN_START, TX_VALID, RX_BUSY} !== 3'b000) begin
      n_fail++;
      $display("FAIL stray_infer: ns/txv/busy=%b, required 000", {NN_START, TX_VALID, RX_BUSY});
    end
    pulse_nn_done(g.res);
    LOAD_DONE = 1'b1; NN_DONE = 1'b1; NN_RESULT = 8'hEE;
    tick();
    LOAD_DONE = 1'b0; NN_DONE = 1'b0;
    n_checks++;
    if ({TX_VALID, TX_RESULT} !== {1'b1, g.res}) begin
      n_fail++;
      $display("FAIL stray_send: txv/res=%b/%h, required 1/%h", TX_VALID, TX_RESULT, g.res);
    end
    tx_accept("stray");
  endtask

  task automatic test_reset_mid_job();
    reply_t h = mk(32'h0A00_0008, 48'h0200_0000_0008, 16'd8008, 8'h99);
    reply_t j = mk(32'h0A00_000A, 48'h0200_0000_000A, 16'd1010, 8'h00);
    reply_t i = mk(32'h0A00_0009, 48'h0200_0000_0009, 16'd9009, 8'h01);
    sb_q.push_back(h);
    drive_frame(h);
    tick();
    pulse_load_done();
    drive_frame(j);
    pulse_nn_done(h.res);
    ARESET = 1'b1;
    #2;
    n_checks++;
    if ({TX_VALID, RX_BUSY, LOAD_START, NN_START} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_ctrl: txv/busy/ls/ns=%b, required 0000",
               {TX_VALID, RX_BUSY, LOAD_START, NN_START});
    end
    n_checks++;
    if ({DROP_COUNT, TIMEOUT_COUNT, TX_RESULT, SRC_IP_ADDRESS_NN} !== '0) begin
      n_fail++;
      $display("FAIL midreset_regs: drop=%0d tmo=%0d res=%h ip=%h, required all 0",
               DROP_COUNT, TIMEOUT_COUNT, TX_RESULT, SRC_IP_ADDRESS_NN);
    end
    sb_q.delete();
    exp_drops = 0;
    last_res  = '0;
    tick();
    ARESET = 1'b0;
    tick(2);
    n_checks++;
    if ({RX_BUSY, LOAD_START} !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_slot_lost: busy/ls=%b, required 00", {RX_BUSY, LOAD_START});
    end
    sb_q.push_back(i);
    drive_frame(i);
    tick();
    pulse_load_done();
    pulse_nn_done(i.res);
    tx_accept("midreset_recover");
  endtask

`ifdef NN_JOB_WATCHDOG_EN
  task automatic test_watchdog();
    reply_t k   = mk(32'h0A00_000B, 48'h0200_0000_000B, 16'd1111, 8'h00);
    bit     bad = 1'b0;
    drive_frame(k);
    tick();
    pulse_load_done();
    for (int n = 1; n < TB_TIMEOUT; n++) begin
      tick();
      if ({NN_ABORT, TX_VALID} !== 2'b00) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL wd_early: NN_ABORT/TX_VALID asserted before %0d INFER cycles, required 0", TB_TIMEOUT);
    end
    tick();
    n_checks++;
    if ({NN_ABORT, TX_VALID} !== 2'b10) begin
      n_fail++;
      $display("FAIL wd_abort: abort/txv=%b at INFER+%0d, required 10", {NN_ABORT, TX_VALID}, TB_TIMEOUT);
    end
    tick();
    n_checks++;
    if ({NN_ABORT, TX_VALID, RX_BUSY, TIMEOUT_COUNT} !== {3'b000, 8'd1}) begin
      n_fail++;
      $display("FAIL wd_after: abort/txv/busy=%b tmo=%0d, required 000 1",
               {NN_ABORT, TX_VALID, RX_BUSY}, TIMEOUT_COUNT);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_job();
    test_overlap();
    test_drops();
    test_stray_handshakes();
    test_reset_mid_job();
`ifdef NN_JOB_WATCHDOG_EN
    test_watchdog();
`endif
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d replies outstanding, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
